// File: rtl/t05_htree_pkg.sv
// Shared types and helpers for the Huffman tree node builder.
// Holds the FSM state type, the NULL child code, the internal-node test and
// the node record field offsets.
package t05_htree_pkg;

    // Widest child code the helpers accept; CHILD_W must not exceed this.
    localparam int unsigned MAX_CHILD_W = 32;

    // NULL child: internal flag set and an all-ones payload.
    localparam logic [MAX_CHILD_W-1:0] NULL_CHILD = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_NODE,
        RD_C1,
        WB_C1,
        RD_C2,
        WB_C2,
        FINISH,
        HALT
    } htree_state_e;

    // Bit SYM_W of a child code marks an internal node.
    function automatic logic is_internal(input logic [MAX_CHILD_W-1:0] child,
                                         input int unsigned sym_w);
        return |(child & (MAX_CHILD_W'(1) << sym_w));
    endfunction

    // Record layout, MSB to LSB: {index, least1, least2, sum}.
    function automatic int unsigned off_sum();
        return 0;
    endfunction

    function automatic int unsigned off_least2(input int unsigned freq_w);
        return freq_w;
    endfunction

    function automatic int unsigned off_least1(input int unsigned freq_w,
                                               input int unsigned child_w);
        return freq_w + child_w;
    endfunction

    function automatic int unsigned off_index(input int unsigned freq_w,
                                              input int unsigned child_w);
        return freq_w + 2 * child_w;
    endfunction

    function automatic int unsigned node_width(input int unsigned idx_w,
                                               input int unsigned child_w,
                                               input int unsigned freq_w);
        return idx_w + 2 * child_w + freq_w;
    endfunction

endpackage

// File: rtl/t05_htree_mem_port.sv
// Node SRAM request port: holds req/we/addr/wdata from start until the ack
// is sampled, and remembers a completion that arrives while the FSM is
// stalled so the FSM can pick it up later.
module t05_htree_mem_port #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 71
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata
);

    logic              ack_evt;
    logic              pend;
    logic [DATA_W-1:0] rdata_q;

    assign ack_evt     = mem_req & mem_ack;
    assign busy        = mem_req;
    assign rdata_valid = ack_evt | pend;
    assign rdata       = ack_evt ? mem_rdata : rdata_q;

    // Request registers: load on start, drop on ack; completion kept until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pend      <= 1'b0;
        end else begin
            if (ack_evt) begin
                mem_req <= 1'b0;
            end else if (start && !mem_req) begin
                mem_req   <= 1'b1;
                mem_we    <= start_we;
                mem_addr  <= start_addr;
                mem_wdata <= start_wdata;
            end
            pend <= (pend | ack_evt) & ~clr;
        end
    end

    // Read data capture for completions consumed after the ack cycle.
    always_ff @(posedge clk) begin
        if (ack_evt) rdata_q <= mem_rdata;
    end

endmodule

// File: rtl/t05_htree_node_builder.sv
// Huffman tree node builder: writes one internal node per accepted pair,
// retires the internal children it consumed, and flags tree completion.
// Optional macro HT_PARENT_LINK_EN: retired children store their parent
// index in the sum field instead of zero.
module t05_htree_node_builder
    import t05_htree_pkg::*;
#(
    parameter  int IDX_W     = 7,
    parameter  int SYM_W     = 8,
    parameter  int FREQ_W    = 46,
    parameter  int MAX_NODES = 127,
    localparam int CHILD_W   = SYM_W + 1,
    localparam int NODE_W    = node_width(IDX_W, CHILD_W, FREQ_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHILD_W-1:0] least1,
    input  logic [CHILD_W-1:0] least2,
    input  logic [FREQ_W-1:0]  sum,
    output logic               mem_req,
    output logic               mem_we,
    output logic [IDX_W-1:0]   mem_addr,
    output logic [NODE_W-1:0]  mem_wdata,
    input  logic [NODE_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [IDX_W:0]     node_count,
    output logic [IDX_W-1:0]   root_idx,
    output logic               done,
    output logic               overflow
);

    localparam logic [CHILD_W-1:0] NULL_C   = NULL_CHILD[CHILD_W-1:0];
    localparam logic [IDX_W:0]     FULL_CNT = (IDX_W+1)'(MAX_NODES + 1);
    localparam int unsigned        OFF_L2   = off_least2(FREQ_W);
    localparam logic [NODE_W-1:0]  KEEP_MASK = {{(NODE_W-OFF_L2){1'b1}}, {OFF_L2{1'b0}}};

    function automatic logic child_int(input logic [CHILD_W-1:0] c);
        return is_internal(MAX_CHILD_W'(c), SYM_W);
    endfunction

    htree_state_e       state;
    logic               rdy_q;
    logic [CHILD_W-1:0] l1_q;
    logic [CHILD_W-1:0] l2_q;
    logic [IDX_W-1:0]   nc_idx;
    logic               accept;
    logic               finish_c;
    logic               malformed_c;
    logic               full_c;
    logic               c1_int;
    logic               c2_int;
    logic               start;
    logic               start_we;
    logic [IDX_W-1:0]   start_addr;
    logic [NODE_W-1:0]  start_wdata;
    logic               busy;
    logic               rdata_valid;
    logic [NODE_W-1:0]  rdata;
    logic               done_ok;
    logic               issue_ok;
    logic [NODE_W-1:0]  retire_sum;
    logic [NODE_W-1:0]  retired;

    assign in_ready    = en & rdy_q;
    assign accept      = in_valid & in_ready;
    assign nc_idx      = node_count[IDX_W-1:0];
    assign finish_c    = ((least2 == NULL_C) && child_int(least1)) ||
                         ((least1 == NULL_C) && (least2 == NULL_C));
    assign malformed_c = (least1 == least2) && child_int(least1) && child_int(least2);
    assign full_c      = (node_count == FULL_CNT);
    assign c1_int      = child_int(l1_q) && (l1_q != NULL_C);
    assign c2_int      = child_int(l2_q) && (l2_q != NULL_C);
    assign done_ok     = en & rdata_valid;
    assign issue_ok    = en & ~busy & ~rdata_valid;

`ifdef HT_PARENT_LINK_EN
    // The new parent is the node written just before the retire sequence.
    logic [IDX_W-1:0] parent_idx;
    assign parent_idx = nc_idx - IDX_W'(1);
    assign retire_sum = NODE_W'(parent_idx);
`else
    assign retire_sum = '0;
`endif

    assign retired = (rdata & KEEP_MASK) | retire_sum;

    // Request issue: the node write starts in the accept cycle, child
    // reads and write-backs start once their state is entered and idle.
    always_comb begin
        start       = 1'b0;
        start_we    = 1'b0;
        start_addr  = '0;
        start_wdata = '0;
        case (state)
            IDLE: begin
                if (accept && !finish_c && !malformed_c && !full_c) begin
                    start       = 1'b1;
                    start_we    = 1'b1;
                    start_addr  = nc_idx;
                    start_wdata = {nc_idx, least1, least2, sum};
                end
            end
            RD_C1: begin
                start      = issue_ok;
                start_addr = l1_q[IDX_W-1:0];
            end
            WB_C1: begin
                start       = issue_ok;
                start_we    = 1'b1;
                start_addr  = l1_q[IDX_W-1:0];
                start_wdata = retired;
            end
            RD_C2: begin
                start      = issue_ok;
                start_addr = l2_q[IDX_W-1:0];
            end
            WB_C2: begin
                start       = issue_ok;
                start_we    = 1'b1;
                start_addr  = l2_q[IDX_W-1:0];
                start_wdata = retired;
            end
            default: ;
        endcase
    end

    // Control FSM; every transition waits for en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdy_q      <= 1'b0;
            node_count <= '0;
            root_idx   <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        rdy_q <= 1'b0;
                        if (finish_c) begin
                            root_idx <= (least1 == NULL_C) ? (nc_idx - IDX_W'(1))
                                                           : least1[IDX_W-1:0];
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (malformed_c || full_c) begin
                            overflow <= 1'b1;
                            state    <= HALT;
                        end else begin
                            state <= WR_NODE;
                        end
                    end
                end
                WR_NODE: begin
                    if (done_ok) begin
                        node_count <= node_count + (IDX_W+1)'(1);
                        if (c1_int) begin
                            state <= RD_C1;
                        end else if (c2_int) begin
                            state <= RD_C2;
                        end else begin
                            state <= IDLE;
                            rdy_q <= 1'b1;
                        end
                    end
                end
                RD_C1: if (done_ok) state <= WB_C1;
                WB_C1: begin
                    if (done_ok) begin
                        if (c2_int) begin
                            state <= RD_C2;
                        end else begin
                            state <= IDLE;
                            rdy_q <= 1'b1;
                        end
                    end
                end
                RD_C2: if (done_ok) state <= WB_C2;
                WB_C2: begin
                    if (done_ok) begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end
                end
                FINISH: if (en) state <= HALT;
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Child codes of the accepted pair, used by the retire sequence.
    always_ff @(posedge clk) begin
        if (accept) begin
            l1_q <= least1;
            l2_q <= least2;
        end
    end

    t05_htree_mem_port #(
        .ADDR_W (IDX_W),
        .DATA_W (NODE_W)
    ) u_mem_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (start_we),
        .start_addr  (start_addr),
        .start_wdata (start_wdata),
        .clr         (done_ok),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .rdata_valid (rdata_valid),
        .rdata       (rdata)
    );

endmodule
